pll_lock_sequencer: RTL
=======================

Name: pll_lock_sequencer

Overview:
- Controls one iCE40 SB_PLL40_CORE from the reference-clock domain.
- Sequences the PLL's RESETB and BYPASS pins, and qualifies its LOCK output.
- Drives o_pll_ready. Downstream logic clocked by the PLL output must stay idle until o_pll_ready is 1.
- Retries a failed lock a bounded number of times, then falls back to bypass.

Parameters:
- RESET_CYCLES, 16: cycles RESETB is held low on each reset attempt.
- STABLE_CYCLES, 256: consecutive synchronised-lock-high cycles required before ready.
- TIMEOUT_CYCLES, 65536: maximum cycles in WAIT_LOCK before an attempt is declared failed.
- MAX_RETRIES, 3: number of failed attempts tolerated; the next failure enters FAIL.
- LOSS_FILTER, 4: consecutive lock-low cycles in RUN that count as loss of lock.

Ports:
- i_clock, input, 1: reference clock; the only clock of this block.
- i_reset_n, input, 1: asynchronous active-low reset.
- i_pll_lock, input, 1: PLL LOCK pin; asynchronous to i_clock.
- i_relock, input, 1: single-cycle request to re-run the full sequence.
- o_pll_resetb, output, 1: drives PLL RESETB.
- o_pll_bypass, output, 1: drives PLL BYPASS.
- o_pll_ready, output, 1: PLL output is locked and usable.
- o_fail, output, 1: retries exhausted; block is in bypass.
- o_state, output, 3: current state encoding, for LEDs or debug.
- o_retry_count, output, 2: failed attempts so far (saturating).

Behaviour:
- Lock synchroniser:
  - i_pll_lock passes through a 2-flop synchroniser; the result is lock_s.
  - All decisions use lock_s, so there is 2 cycles of latency from i_pll_lock.
- Reset (i_reset_n = 0), asynchronous:
  - state = RESET, counter = 0, retry = 0, synchroniser flops = 0.
  - o_pll_resetb = 0, o_pll_bypass = 0, o_pll_ready = 0, o_fail = 0.
  - All outputs are registered.
- State encodings: RESET = 0, WAIT_LOCK = 1, RUN = 2, FAIL = 3.
- RESET:
  - o_pll_resetb = 0.
  - Counter counts 0 .. RESET_CYCLES-1. At RESET_CYCLES-1, go to WAIT_LOCK and clear the counter.
- WAIT_LOCK:
  - o_pll_resetb = 1.
  - Stable counter: increments while lock_s = 1 and clears to 0 whenever lock_s = 0.
  - When the stable counter reaches STABLE_CYCLES-1 with lock_s = 1, go to RUN.
  - A separate timeout counter increments every cycle.
  - On reaching TIMEOUT_CYCLES-1:
    - retry < MAX_RETRIES: retry += 1, go to RESET.
    - otherwise: go to FAIL.
  - If stable completion and timeout occur in the same cycle, stable completion wins (go to RUN).
- RUN:
  - o_pll_ready = 1, o_pll_resetb = 1.
  - Retry count clears to 0 on entry.
  - Loss counter: increments on lock_s = 0 and clears on lock_s = 1.
  - At LOSS_FILTER consecutive lows: o_pll_ready drops in the same registered update, and state goes to RESET.
  - A lock-low glitch shorter than LOSS_FILTER cycles leaves o_pll_ready = 1.
- FAIL:
  - o_pll_bypass = 1, o_pll_resetb = 0, o_fail = 1, o_pll_ready = 1.
  - o_pll_ready = 1 here because the bypassed reference clock is usable.
  - The block stays in FAIL until i_relock or reset.
- i_relock:
  - In any state, i_relock = 1 forces the next state to RESET.
  - It clears retry, o_fail and o_pll_bypass, and drops o_pll_ready the next cycle.
  - i_relock takes priority over every other transition in the same cycle.
  - i_relock asserted while already in RESET restarts RESET_CYCLES from 0.
- Counters:
  - One shared phase counter of width $clog2(max(RESET_CYCLES, TIMEOUT_CYCLES)) + 1, plus separate stable and loss counters.
  - Every counter clears on each state transition.
  - No counter may wrap.
- o_retry_count saturates at 3.
- Illegal o_state values (4-7) recover to RESET on the next cycle.

Test Plan:
- Nominal lock, RESET_CYCLES=16, STABLE_CYCLES=8:
  - Release reset, raise i_pll_lock at cycle 20.
  - o_pll_resetb rises at cycle 16.
  - o_pll_ready rises at cycle 20 + 2 + 8 (±1 per the registered-output rule); o_state = 2.
- Flicker during qualification:
  - Lock high for 5 cycles, low 1 cycle, then high.
  - The stable count restarts; ready is asserted 8 cycles after the final rise plus 2 sync cycles.
- Timeout and retry, TIMEOUT_CYCLES=32, MAX_RETRIES=2, lock held low:
  - o_pll_resetb shows 3 low pulses, o_retry_count goes 1 then 2.
  - Then o_state = 3, o_fail = 1, o_pll_bypass = 1, o_pll_ready = 1.
- Loss of lock in RUN, LOSS_FILTER=4:
  - A 3-cycle low keeps ready = 1.
  - A 4-cycle low drops ready, o_state = 0, o_pll_resetb = 0.
  - On relock the sequence completes with o_retry_count = 0.
- Relock from FAIL:
  - i_relock pulse gives o_fail = 0, o_pll_bypass = 0, o_state = 0 next cycle.
  - With lock present afterwards, the block reaches RUN.
- Async reset mid-WAIT_LOCK:
  - Assert i_reset_n = 0 between clock edges.
  - All outputs go to reset values immediately, without waiting for a clock edge.
  - After release, the full RESET_CYCLES sequence repeats.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: sequences SB_PLL40_CORE RESETB/BYPASS and qualifies LOCK
module pll_lock_sequencer #(
    parameter int RESET_CYCLES   = 16,
    parameter int STABLE_CYCLES  = 256,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES    = 3,
    parameter int LOSS_FILTER    = 4
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_pll_lock,
    input  logic       i_relock,
    output logic       o_pll_resetb,
    output logic       o_pll_bypass,
    output logic       o_pll_ready,
    output logic       o_fail,
    output logic [2:0] o_state,
    output logic [1:0] o_retry_count
);
    localparam int MAX_CYC = (RESET_CYCLES > TIMEOUT_CYCLES) ? RESET_CYCLES : TIMEOUT_CYCLES;
    localparam int PW = $clog2(MAX_CYC) + 1;
    localparam int SW = $clog2(STABLE_CYCLES) + 1;
    localparam int LW = $clog2(LOSS_FILTER) + 1;
    localparam logic [PW-1:0] RESET_LAST   = PW'(RESET_CYCLES - 1);
    localparam logic [PW-1:0] TIMEOUT_LAST = PW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_LAST  = SW'(STABLE_CYCLES - 1);
    localparam logic [LW-1:0] LOSS_LAST    = LW'(LOSS_FILTER - 1);

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_RUN       = 3'd2,
        S_FAIL      = 3'd3
    } state_t;

    state_t          state;
    state_t          nxt;
    logic            restart;
    logic            lock_m;
    logic            lock_s;
    logic [PW-1:0]   phase;
    logic [SW-1:0]   stable;
    logic [LW-1:0]   loss;
    logic [1:0]      retry;

    assign o_state       = state;
    assign o_retry_count = retry;

    // two-flop synchroniser for the asynchronous LOCK pin
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= i_pll_lock;
            lock_s <= lock_m;
        end
    end

    // next-state selection; relock overrides everything, illegal codes fall back to RESET
    always_comb begin
        nxt = state;
        case (state)
            S_RESET:     nxt = (phase == RESET_LAST) ? S_WAIT_LOCK : S_RESET;
            S_WAIT_LOCK: nxt = (lock_s && stable == STABLE_LAST) ? S_RUN :
                               (phase != TIMEOUT_LAST) ? S_WAIT_LOCK :
                               (int'(retry) < MAX_RETRIES) ? S_RESET : S_FAIL;
            S_RUN:       nxt = (!lock_s && loss == LOSS_LAST) ? S_RESET : S_RUN;
            S_FAIL:      nxt = S_FAIL;
            default:     nxt = S_RESET;
        endcase
        if (i_relock) nxt = S_RESET;
        restart = i_relock || (nxt != state);
    end

    // state, counters and outputs registered together; outputs follow the state being entered
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= S_RESET;
            phase        <= '0;
            stable       <= '0;
            loss         <= '0;
            retry        <= '0;
            o_pll_resetb <= 1'b0;
            o_pll_bypass <= 1'b0;
            o_pll_ready  <= 1'b0;
            o_fail       <= 1'b0;
        end else begin
            state  <= nxt;
            phase  <= (restart || !(state == S_RESET || state == S_WAIT_LOCK)) ? '0 : phase + 1'b1;
            stable <= (restart || state != S_WAIT_LOCK || !lock_s) ? '0 : stable + 1'b1;
            loss   <= (restart || state != S_RUN || lock_s) ? '0 : loss + 1'b1;
            if (i_relock || (nxt == S_RUN && state != S_RUN))
                retry <= '0;
            else if (state == S_WAIT_LOCK && nxt == S_RESET)
                retry <= (retry == 2'd3) ? retry : retry + 2'd1;
            o_pll_resetb <= (nxt == S_WAIT_LOCK) || (nxt == S_RUN);
            o_pll_bypass <= (nxt == S_FAIL);
            o_fail       <= (nxt == S_FAIL);
            o_pll_ready  <= (nxt == S_RUN) || (nxt == S_FAIL);
        end
    end
endmodule
